// File: rtl/prewish_mask_sched.sv
// prewish_mask_sched: arbitrates a debounced DIP-load button and an auto-cycle
// pattern timer onto the single strobe/data input of prewish_mentor. Every
// grant is one single-cycle strobe followed by a fixed idle gap.
module prewish_mask_sched #(
    parameter int DEBOUNCE_BITS    = 16,
    parameter int AUTO_PERIOD_BITS = 26,
    parameter int GAP_CYCLES       = 4
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_load_btn,
    input  logic [7:0] i_dip,
    input  logic       i_auto_en,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic [1:0] o_src,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    // Fixed auto-cycle mask sequence.
    function automatic logic [7:0] pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pattern = 8'h80;
            3'd1:    pattern = 8'hA0;
            3'd2:    pattern = 8'hA8;
            3'd3:    pattern = 8'hFF;
            3'd4:    pattern = 8'hD4;
            3'd5:    pattern = 8'hD5;
            3'd6:    pattern = 8'hCC;
            default: pattern = 8'hE0;
        endcase
    endfunction

    logic                        btn_sync_p0;
    logic                        btn_s;
    logic [DEBOUNCE_BITS-1:0]    db_cnt;
    logic                        btn_stable;
    logic                        btn_stable_d;
    logic                        btn_rise;
    logic                        btn_pend;
    logic [7:0]                  btn_data;
    logic [AUTO_PERIOD_BITS-1:0] auto_cnt;
    logic                        auto_pend;
    logic [2:0]                  auto_idx;

    state_t     state, state_n;
    logic [3:0] gap_cnt, gap_cnt_n;
    logic       stb_n;
    logic [7:0] dat_n;
    logic [1:0] src_n;
    logic       btn_grant;
    logic       auto_grant;

    // A press is the rising edge of the debounced level; releases are ignored.
    assign btn_rise = btn_stable & ~btn_stable_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            btn_sync_p0 <= 1'b0;
            btn_s       <= 1'b0;
        end else begin
            btn_sync_p0 <= i_load_btn;
            btn_s       <= btn_sync_p0;
        end
    end

    // Debounce: a new level must persist until the counter saturates.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            db_cnt       <= '0;
            btn_stable   <= 1'b0;
            btn_stable_d <= 1'b0;
        end else begin
            if (btn_s == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == '1) begin
                btn_stable <= btn_s;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            btn_stable_d <= btn_stable;
        end
    end

    // Button request flag; a new press in the same cycle as a grant wins.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            btn_pend <= 1'b0;
        end else if (btn_rise) begin
            btn_pend <= 1'b1;
        end else if (btn_grant) begin
            btn_pend <= 1'b0;
        end
    end

    // DIP capture on each accepted press; last press wins.
    always_ff @(posedge CLK_I) begin
        if (btn_rise) begin
            btn_data <= i_dip;
        end
    end

    // Auto timer and request flag; disabling cancels any pending request.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else if (!i_auto_en) begin
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
            if (auto_cnt == '1) begin
                auto_pend <= 1'b1;
            end else if (auto_grant) begin
                auto_pend <= 1'b0;
            end
        end
    end

    // Pattern index advances once per auto grant.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            auto_idx <= 3'd0;
        end else if (auto_grant) begin
            auto_idx <= auto_idx + 3'd1;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state   <= IDLE;
            gap_cnt <= 4'd0;
            STB_O   <= 1'b0;
            DAT_O   <= 8'h00;
            o_src   <= 2'b00;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
            STB_O   <= stb_n;
            DAT_O   <= dat_n;
            o_src   <= src_n;
            o_busy  <= (state != IDLE);
        end
    end

    // Next-state and grant decode; button has priority over auto.
    always_comb begin
        state_n    = state;
        gap_cnt_n  = gap_cnt;
        stb_n      = 1'b0;
        dat_n      = DAT_O;
        src_n      = o_src;
        btn_grant  = 1'b0;
        auto_grant = 1'b0;
        case (state)
            IDLE: begin
                if (btn_pend) begin
                    stb_n     = 1'b1;
                    dat_n     = btn_data;
                    src_n     = 2'b01;
                    btn_grant = 1'b1;
                    state_n   = STROBE;
                end else if (auto_pend) begin
                    stb_n      = 1'b1;
                    dat_n      = pattern(auto_idx);
                    src_n      = 2'b10;
                    auto_grant = 1'b1;
                    state_n    = STROBE;
                end
            end
            STROBE: begin
                gap_cnt_n = GAP_LOAD;
                state_n   = GAP;
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prewish_mask_sched.sv
// Directed testbench for prewish_mask_sched with short debounce, auto period
// and gap so every scenario completes in a few hundred cycles.
module tb_prewish_mask_sched;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn     = 1'b0;
    logic [7:0] dip     = 8'h00;
    logic       auto_en = 1'b0;
    logic       stb;
    logic [7:0] dat;
    logic [1:0] src;
    logic       busy;

    prewish_mask_sched #(
        .DEBOUNCE_BITS   (2),
        .AUTO_PERIOD_BITS(4),
        .GAP_CYCLES      (2)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst_n),
        .i_load_btn(btn),
        .i_dip     (dip),
        .i_auto_en (auto_en),
        .STB_O     (stb),
        .DAT_O     (dat),
        .o_src     (src),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic [1:0] s;
    } stb_rec_t;

    stb_rec_t q[$];
    int       cyc       = 0;
    int       n_chk     = 0;
    int       n_pass    = 0;
    int       width_err = 0;
    logic     stb_prev  = 1'b0;
    int       c0;
    bit       found;

    logic [7:0] exp_auto [9] = '{8'h80, 8'hA0, 8'hA8, 8'hFF, 8'hD4,
                                 8'hD5, 8'hCC, 8'hE0, 8'h80};

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder: logs every strobe and flags any wider than one cycle.
    always @(negedge clk) begin
        if (stb === 1'b1) begin
            q.push_back('{cyc, dat, src});
            if (stb_prev === 1'b1) width_err++;
        end
        stb_prev = stb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stb(input int maxc, output bit f);
        f = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (stb === 1'b1) begin
                f = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn     = i[0];
            dip     = 8'hA5 ^ 8'(i);
            auto_en = ~i[0];
            #1;
            check("rst_stb", stb, 1'b0);
            check("rst_dat", dat, 8'h00);
            check("rst_src", src, 2'b00);
            check("rst_busy", busy, 1'b0);
        end
        @(negedge clk);
        btn = 1'b0; dip = 8'h00; auto_en = 1'b0; rst_n = 1'b1;
        tick(50);
        check("idle_no_stb", q.size(), 0);

        // Clean press
        @(negedge clk);
        c0 = cyc; dip = 8'h5A; btn = 1'b1;
        wait_stb(12, found);
        check("press_seen", found, 1'b1);
        check("press_lat", cyc - c0, 8);
        check("press_dat", dat, 8'h5A);
        check("press_src", src, 2'b01);
        check("press_busy_stb", busy, 1'b0);
        @(negedge clk);
        check("press_width", stb, 1'b0);
        check("press_busy_gap", busy, 1'b1);
        tick(1);
        btn = 1'b0;
        tick(30);
        check("press_count", q.size(), 1);
        check("press_hold", dat, 8'h5A);
        q.delete();

        // Bounce alone, then bounce followed by a stable press
        dip = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn = ((i / 2) % 2 == 0);
        end
        @(negedge clk);
        btn = 1'b0;
        tick(20);
        check("bounce_only", q.size(), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn = ((i / 2) % 2 == 0);
        end
        @(negedge clk);
        btn = 1'b1;
        tick(15);
        btn = 1'b0;
        tick(20);
        check("bounce_count", q.size(), 1);
        if (q.size() >= 1) begin
            check("bounce_dat", q[0].d, 8'h3C);
            check("bounce_src", q[0].s, 2'b01);
        end
        q.delete();

        // Auto sequence over nine periods
        @(negedge clk);
        c0 = cyc; auto_en = 1'b1;
        tick(148);
        auto_en = 1'b0;
        tick(2);
        check("auto_count", q.size(), 9);
        for (int k = 0; k < 9 && k < q.size(); k++) begin
            check($sformatf("auto_cyc%0d", k), q[k].c - c0, 17 + 16 * k);
            check($sformatf("auto_dat%0d", k), q[k].d, exp_auto[k]);
            check($sformatf("auto_src%0d", k), q[k].s, 2'b10);
        end
        q.delete();

        // Collision: both pends set on the same edge
        @(negedge clk);
        c0 = cyc; auto_en = 1'b1; dip = 8'hC3;
        tick(9);
        btn = 1'b1;
        tick(15);
        auto_en = 1'b0; btn = 1'b0;
        tick(20);
        check("coll_count", q.size(), 2);
        if (q.size() >= 2) begin
            check("coll_btn_cyc", q[0].c - c0, 17);
            check("coll_btn_dat", q[0].d, 8'hC3);
            check("coll_btn_src", q[0].s, 2'b01);
            check("coll_auto_cyc", q[1].c - c0, 21);
            check("coll_auto_dat", q[1].d, 8'hA0);
            check("coll_auto_src", q[1].s, 2'b10);
        end
        q.delete();

        // Cancellation: auto enable drops while auto request waits in GAP
        @(negedge clk);
        c0 = cyc; auto_en = 1'b1; dip = 8'h96;
        tick(7);
        btn = 1'b1;
        tick(9);
        auto_en = 1'b0; btn = 1'b0;
        tick(24);
        check("cancel_count", q.size(), 1);
        if (q.size() >= 1) begin
            check("cancel_cyc", q[0].c - c0, 15);
            check("cancel_dat", q[0].d, 8'h96);
        end
        check("cancel_src", src, 2'b01);
        q.delete();

        // Auto resumes at the unchanged index
        @(negedge clk);
        c0 = cyc; auto_en = 1'b1;
        wait_stb(20, found);
        check("resume_seen", found, 1'b1);
        check("resume_lat", cyc - c0, 17);
        check("resume_dat", dat, 8'hA8);
        check("resume_src", src, 2'b10);
        wait_stb(20, found);
        check("prerst_seen", found, 1'b1);
        check("prerst_dat", dat, 8'hFF);

        // Reset pulse during the strobe cycle
        rst_n = 1'b0;
        #1;
        check("midrst_stb", stb, 1'b0);
        check("midrst_dat", dat, 8'h00);
        check("midrst_src", src, 2'b00);
        check("midrst_busy", busy, 1'b0);
        #1;
        rst_n = 1'b1;
        c0 = cyc;
        wait_stb(24, found);
        check("postrst_seen", found, 1'b1);
        check("postrst_lat", cyc - c0, 17);
        check("postrst_dat", dat, 8'h80);
        check("postrst_src", src, 2'b10);
        auto_en = 1'b0;
        tick(5);
        check("strobe_width", width_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
